// File: rtl/complete_stage_pkg.sv
// Shared types for the complete stage: FU completion packets, CDB lanes and
// ROB completion packets, plus FU slot indices.
package complete_stage_pkg;

  localparam int XLEN  = 32;
  localparam int FU    = 3;
  localparam int N_FU  = 2 ** FU;
  localparam int N_CDB = 3;
  localparam int PR_W  = 6;
  localparam int ROB_W = 5;

  localparam int ALU_1  = 0;
  localparam int ALU_2  = 1;
  localparam int ALU_3  = 2;
  localparam int MULT_1 = 3;
  localparam int MULT_2 = 4;
  localparam int LS_1   = 5;
  localparam int LS_2   = 6;
  localparam int BRANCH = 7;

  typedef logic [N_FU-1:0] FU_STATE_PACKET;

  typedef struct packed {
    logic              valid;
    logic [PR_W-1:0]   dest_pr;
    logic [XLEN-1:0]   dest_value;
    logic [ROB_W-1:0]  rob_entry;
    logic              if_take_branch;
    logic [XLEN-1:0]   target_pc;
    logic              halt;
  } FU_COMPLETE_PACKET;

  typedef struct packed {
    logic            t_valid;
    logic [PR_W-1:0] tag;
  } CDB_T_PACKET;

  typedef struct packed {
    logic [ROB_W-1:0] rob_entry;
    logic             precise_state_need;
    logic [XLEN-1:0]  target_pc;
    logic             halt;
  } CDB_ROB_PACKET;

  // A taken/mispredicted branch is what forces the ROB into precise state.
  function automatic CDB_ROB_PACKET to_rob(FU_COMPLETE_PACKET p);
    CDB_ROB_PACKET r;
    r.rob_entry          = p.rob_entry;
    r.precise_state_need = p.if_take_branch;
    r.target_pc          = p.target_pc;
    r.halt               = p.halt;
    return r;
  endfunction

endpackage

// File: rtl/complete_stage_if.sv
// FU-side requests and CDB/ROB-side results of the complete stage.
interface complete_stage_if #(
  parameter int N_FU  = complete_stage_pkg::N_FU,
  parameter int N_CDB = complete_stage_pkg::N_CDB
);
  import complete_stage_pkg::*;

  logic                                squash;
  logic [N_FU-1:0]                     fu_finish;
  FU_COMPLETE_PACKET [N_FU-1:0]        fu_c_in;
  logic [N_FU-1:0]                     fu_c_stall;
  CDB_T_PACKET [N_CDB-1:0]             cdb_t;
  logic [N_CDB-1:0][XLEN-1:0]          cdb_value;
  logic [N_CDB-1:0]                    complete_valid;
  CDB_ROB_PACKET [N_CDB-1:0]           complete_rob;

  modport slave (
    input  squash, fu_finish, fu_c_in,
    output fu_c_stall, cdb_t, cdb_value, complete_valid, complete_rob
  );

  modport master (
    output squash, fu_finish, fu_c_in,
    input  fu_c_stall, cdb_t, cdb_value, complete_valid, complete_rob
  );

endinterface

// File: rtl/complete_stage_rr_multi_arbiter.sv
// Multi-grant rotating-priority arbiter: grants up to N_GNT requesters in
// scan order starting at ptr. N_REQ must be a power of two.
module rr_multi_arbiter #(
  parameter int N_REQ = 8,
  parameter int N_GNT = 3,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]              req,
  input  logic [PTR_W-1:0]              ptr,
  output logic [N_REQ-1:0]              grant,
  output logic [N_GNT-1:0]              lane_valid,
  output logic [N_GNT-1:0][PTR_W-1:0]   lane_idx,
  output logic [PTR_W-1:0]              next_ptr
);

  localparam int CNT_W = $clog2(N_GNT + 1);

  // The index adder wraps naturally at N_REQ, giving the modular scan for free.
  always_comb begin : scan
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] idx;
    grant      = '0;
    lane_valid = '0;
    lane_idx   = '0;
    next_ptr   = ptr;
    cnt        = '0;
    idx        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + PTR_W'(k);
      if (req[idx] && (cnt < CNT_W'(N_GNT))) begin
        grant[idx]      = 1'b1;
        lane_valid[cnt] = 1'b1;
        lane_idx[cnt]   = idx;
        next_ptr        = idx + PTR_W'(1);
        cnt             = cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/complete_stage.sv
// Complete stage: arbitrates FU completions onto N_CDB registered CDB lanes
// and back-pressures the losers combinationally.
module complete_stage #(
  parameter int N_FU  = complete_stage_pkg::N_FU,
  parameter int N_CDB = complete_stage_pkg::N_CDB
) (
  input  logic             clock,
  input  logic             reset,
  complete_stage_if.slave  io
);
  import complete_stage_pkg::*;

  localparam int PTR_W = $clog2(N_FU);

  logic [PTR_W-1:0]               rr_ptr;
  logic [PTR_W-1:0]               next_ptr;
  logic [N_FU-1:0]                req;
  logic [N_FU-1:0]                grant;
  logic [N_CDB-1:0]               lane_valid;
  logic [N_CDB-1:0][PTR_W-1:0]    lane_idx;

  CDB_T_PACKET [N_CDB-1:0]        t_nxt, t_q;
  logic [N_CDB-1:0][XLEN-1:0]     v_nxt, v_q;
  logic [N_CDB-1:0]               cv_nxt, cv_q;
  CDB_ROB_PACKET [N_CDB-1:0]      rob_nxt, rob_q;
  FU_COMPLETE_PACKET              pkt;

  always_comb begin
    for (int i = 0; i < N_FU; i++) begin
      req[i] = io.fu_finish[i] & io.fu_c_in[i].valid;
    end
  end

  rr_multi_arbiter #(
    .N_REQ (N_FU),
    .N_GNT (N_CDB),
    .PTR_W (PTR_W)
  ) arb (
    .req        (req),
    .ptr        (rr_ptr),
    .grant      (grant),
    .lane_valid (lane_valid),
    .lane_idx   (lane_idx),
    .next_ptr   (next_ptr)
  );

  // Nobody is held off while the pipeline is being flushed or reset.
  assign io.fu_c_stall = (reset || io.squash) ? '0 : (req & ~grant);

  // A zero destination still completes in the ROB but must not wake anything.
  always_comb begin
    t_nxt   = '0;
    v_nxt   = '0;
    cv_nxt  = '0;
    rob_nxt = '0;
    pkt     = '0;
    for (int l = 0; l < N_CDB; l++) begin
      if (lane_valid[l]) begin
        pkt              = io.fu_c_in[lane_idx[l]];
        t_nxt[l].t_valid = (pkt.dest_pr != '0);
        t_nxt[l].tag     = pkt.dest_pr;
        v_nxt[l]         = pkt.dest_value;
        cv_nxt[l]        = 1'b1;
        rob_nxt[l]       = to_rob(pkt);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      t_q    <= '0;
      v_q    <= '0;
      cv_q   <= '0;
      rob_q  <= '0;
    end else if (io.squash) begin
      rr_ptr <= '0;
      t_q    <= '0;
      v_q    <= '0;
      cv_q   <= '0;
      rob_q  <= '0;
    end else begin
      rr_ptr <= next_ptr;
      t_q    <= t_nxt;
      v_q    <= v_nxt;
      cv_q   <= cv_nxt;
      rob_q  <= rob_nxt;
    end
  end

  assign io.cdb_t          = t_q;
  assign io.cdb_value      = v_q;
  assign io.complete_valid = cv_q;
  assign io.complete_rob   = rob_q;

endmodule

// File: doc/complete_stage.md
# complete_stage

Complete stage. Sits directly downstream of the execution stage: it takes the per-FU finish requests and completion packets and grants at most `N_CDB` of them per cycle, using rotating priority. It back-pressures the losing FUs through `fu_c_stall` and registers the winners onto the CDB. The registered CDB outputs feed RS/map-table wakeup and physical-register writeback, and the ROB complete/branch-resolution port.

## Interface
Parameters:
- `N_FU`, default 2**`FU (8): FU slots, indexed ALU_1..3, MULT_1..2, LS_1..2, BRANCH.
- `N_CDB`, default 3: CDB broadcast lanes per cycle.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high; one clock, all state reset on assertion.
- `squash`  in  1  precise-state flush from retire.
- `fu_finish`  in  FU_STATE_PACKET (N_FU bits)  per-FU completion request.
- `fu_c_in`  in  FU_COMPLETE_PACKET [N_FU]  per-FU result: valid, dest_pr, dest_value, rob_entry, if_take_branch, target_pc, halt.
- `fu_c_stall`  out  FU_STATE_PACKET  per-FU stall; combinational.
- `cdb_t`  out  CDB_T_PACKET [N_CDB]  registered lanes: t_valid, tag (dest_pr).
- `cdb_value`  out  [N_CDB][`XLEN-1:0]  registered writeback data per lane.
- `complete_valid`  out  [N_CDB]  registered ROB completion valid.
- `complete_rob`  out  CDB_ROB_PACKET [N_CDB]  rob_entry, precise_state_need, target_pc, halt.

## Operation
- Request vector: `req[i] = fu_finish[i] & fu_c_in[i].valid`.
- Rotating priority: 3-bit pointer `rr_ptr`. Scan FU indices `rr_ptr, rr_ptr+1, … (mod N_FU)`. Grant the first up to `N_CDB` requesters, in scan order, to lanes 0..N_CDB-1.
- `fu_c_stall[i] = req[i] & ~grant[i]`. A non-requesting FU is never stalled.
- Pointer update: if ≥1 grant, `rr_ptr <= (index of last granted FU + 1) mod N_FU`. Otherwise it holds. Wrap-around 7→0 is normal.
- Lane register load:
  - Granted packet: lane valid=1.
  - Unused lanes: valid=0, data zeroed.
- `cdb_t.t_valid = 1` only if `dest_pr != 0`. A zero-register destination completes in the ROB with no wakeup and no writeback.
- `precise_state_need = if_take_branch` (branch unit mispredict/taken redirect). `target_pc` is passed through.
- The stage holds no per-FU buffering. A stalled FU must hold `fu_finish` and its packet stable until granted.
- Squash:
  - Next edge clears all lane registers (valids=0, data 0).
  - Any grants made in the squash cycle are discarded.
  - `fu_c_stall` is forced to 0 during squash.
  - `rr_ptr` resets to 0.
- Reset:
  - All `cdb_t`, `cdb_value`, `complete_valid`, `complete_rob` = 0.
  - `rr_ptr` = 0.
  - `fu_c_stall` = 0 while reset is high.

## Timing
- Grant/stall: combinational in the request cycle N.
- CDB and ROB outputs valid in cycle N+1 (1-cycle latency), held exactly one cycle.
- Back-to-back: a FU granted in cycle N may request again in N+1 and compete normally.
- Simultaneous `squash` and requests: squash wins; no lane valid in N+1.
- Reset asserted mid-operation: outputs clear immediately (async). First grants are possible in the first cycle after deassertion.
- Worst case: 8 requests. Exactly 3 granted, 5 stalled. Every requester is granted within ⌈8/3⌉ = 3 cycles; no starvation.

## Structure
- Shared package (sys_defs):
  - `FU_STATE_PACKET`, `FU_COMPLETE_PACKET`, `CDB_T_PACKET`, `CDB_ROB_PACKET`.
  - FU index constants ALU_1..BRANCH, `FU`, `XLEN`, `N_CDB`.
- One sub-module: `rr_multi_arbiter`. Parameterised requesters/grants; `req` + `ptr` → `grant` vector, per-lane index, next pointer. Purely combinational.
- `complete_stage` holds the pointer register, the lane registers, and squash/reset handling.

## Test plan
- Reset: assert reset mid-cycle with lanes valid → all outputs 0 at once. After deassert, one `fu_finish` on ALU_2 with dest_pr=5, value 0x1234 → next cycle lane0 tag 5, value 0x1234, complete_valid[0]=1.
- Saturation: all 8 FUs request, ptr=0:
  - Cycle N grants FUs 0,1,2; stall=0xF8; ptr→3.
  - Cycle N+1 grants 3,4,5; ptr→6.
  - Cycle N+2 grants 6,7; ptr→0.
- Wrap-around: ptr=6, requests {7,0,4} → lanes 0/1/2 = FUs 7, 0, 4; ptr→5.
- Zero destination: MULT_1 completes with dest_pr=0 → complete_valid=1, cdb_t.t_valid=0.
- Branch: BRANCH requests with if_take_branch=1, target 0x80 → next cycle precise_state_need=1, target_pc=0x80.
- Squash: 3 requests in the squash cycle → stall=0, no lane valid next cycle, ptr=0.
